// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: finds mid-bit samples using the external edge/bit counter,
// deserialises LSB-first, checks parity and stop, strobes the byte. Majority voting: UART_RX_MAJORITY_VOTE_EN.
module uart_rx_fsm #(
    parameter int PWIDTH = 6,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic              par_en,
    input  logic              par_typ,
    input  logic [PWIDTH-1:0] prescale,
    input  logic [PWIDTH-1:0] edge_counter,
    input  logic [PWIDTH-2:0] bit_counter,
    output logic              cnt_enable,
    output logic [DWIDTH-1:0] p_data,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              frame_busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t            state;
    logic [DWIDTH-1:0] shift;
    logic              par_bad;
    logic [PWIDTH-1:0] mid;
    logic              eob;
    logic              last_bit;
    logic              sbit;

    assign mid        = prescale >> 1;
    assign eob        = (edge_counter == prescale - PWIDTH'(1));
    assign last_bit   = (bit_counter == (PWIDTH-1)'(DWIDTH));
    assign cnt_enable = state inside {START, DATA, PARITY, STOP};
    assign frame_busy = (state != IDLE);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic s_early, s_mid, s_late;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_early <= 1'b1;
            s_mid   <= 1'b1;
            s_late  <= 1'b1;
        end else begin
            if (edge_counter == mid - PWIDTH'(1)) s_early <= rx_in;
            if (edge_counter == mid)              s_mid   <= rx_in;
            if (edge_counter == mid + PWIDTH'(1)) s_late  <= rx_in;
        end
    end

    assign sbit = (s_early & s_mid) | (s_early & s_late) | (s_mid & s_late);
`else
    logic s_mid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     s_mid <= 1'b1;
        else if (edge_counter == mid) s_mid <= rx_in;
    end

    assign sbit = s_mid;
`endif

    // Strobes are launched on the STOP->DONE edge so they are high exactly while DONE is occupied.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift      <= '0;
            p_data     <= '0;
            par_bad    <= 1'b0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    par_bad <= 1'b0;
                    if (!rx_in) state <= START;
                end
                START: begin
                    if (eob) state <= sbit ? IDLE : DATA;
                end
                DATA: begin
                    if (eob) begin
                        shift <= {sbit, shift[DWIDTH-1:1]};
                        if (last_bit) state <= par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (eob) begin
                        par_bad <= (sbit != ((^shift) ^ par_typ));
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (eob) begin
                        state   <= DONE;
                        stp_err <= !sbit;
                        par_err <= par_bad;
                        if (sbit && !par_bad) begin
                            data_valid <= 1'b1;
                            p_data     <= shift;
                        end
                    end
                end
                DONE: begin
                    par_bad <= 1'b0;
                    state   <= rx_in ? IDLE : START;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
